lcd_bus_decoder: RTL
====================

Name: lcd_bus_decoder

Overview:
- Receiving end of the 4-bit HD44780-style character LCD bus (LCD_E/LCD_RS/LCD_RW/LCD_D) that our LCD driver produces.
- Samples the bus, reassembles nibbles into bytes, and interprets the command subset the driver emits.
- Maintains a 2x16 shadow display, row_A/row_B, in the same 128-bit packing the driver consumes: char 0 at bits [0:7].
- Used as an on-chip mirror for debug/UART readback and as a self-check monitor in bench and board builds.

Parameters:
SYNC_STAGES, 2, number of flops on each bus input before use (min 2)
E_MIN_HIGH, 2, minimum consecutive synchronized LCD_E-high cycles for a strobe to be accepted (glitch filter)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
LCD_E  input  1  bus enable strobe; data is taken on its falling edge
LCD_RS  input  1  0 = command, 1 = data
LCD_RW  input  1  0 = write, 1 = read
LCD_D  input  4  bus nibble
row_A  output  128  shadow line 1, [0:127], char i at [8*i +: 8]
row_B  output  128  shadow line 2, same packing
byte_valid  output  1  one-cycle pulse: a complete byte was decoded
byte_data  output  8  decoded byte, held until next byte_valid
byte_rs  output  1  RS of the decoded byte
frame_update  output  1  one-cycle pulse on a data write to address 0x4F
proto_err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async, reset_n=0): row_A/row_B all 8'h20; state S_MODE8; addr=7'h00; inc=1; byte_valid=0, byte_data=0, byte_rs=0, frame_update=0, proto_err=0; high counter and synchronizers cleared. Reset mid-nibble discards the partial byte.
- Inputs pass through SYNC_STAGES flops.
- Strobe: a synchronized E high-to-low transition after the high counter reached >= E_MIN_HIGH. RS/RW/D are taken from the last E-high cycle. Shorter pulses are ignored silently.
- A strobe with RW=1 is ignored and raises proto_err. Nibble pairing state is unchanged.
- FSM:
  - S_MODE8 (8-bit init phase): a strobe with RS=0 and D=4'h2 goes to S_HI. RS=0 with any other D (e.g. 4'h3 init) is ignored. RS=1 pulses proto_err.
  - S_HI: latch the high nibble and RS, go to S_LO.
  - S_LO: if RS matches the latched RS, form the byte and go to S_HI. On RS mismatch, pulse proto_err, drop both nibbles, go to S_HI.
- Latency: byte_valid, with byte_data/byte_rs, is asserted exactly 1 cycle after the strobe-detect cycle. Row and address updates land on the same edge as byte_valid.
- Command decode (byte_rs=0), priority from MSB:
  - 1aaaaaaa: addr = aaaaaaa.
  - 01xxxxxx (CGRAM set): ignored.
  - 001xxxxx (function set): ignored.
  - 0000001x: addr=0.
  - 00000001: both rows = 8'h20, addr=0, inc=1.
  - 000001ix: inc=i.
  - Others ignored.
- Data (byte_rs=1):
  - addr 0x00..0x0F writes row_A char addr.
  - addr 0x40..0x4F writes row_B char addr-0x40.
  - Other addresses are written nowhere.
  - The address then steps.
- Address step:
  - inc=1: 0x27 -> 0x40, 0x67 -> 0x00, else +1.
  - inc=0: 0x00 -> 0x67, 0x40 -> 0x27, else -1.
  - A set-address outside 0x00..0x27/0x40..0x67 is stored as given; the next step from it is +/-1, 7-bit wrap.
- frame_update pulses with byte_valid when the data write targets 0x4F.
- Strobes are at least E_MIN_HIGH+1 cycles apart, so no two byte events overlap. Clear completes in one cycle.

Optional Feature:
- Macro: LCD_DEC_ERR_CNT_EN.
- Defined: adds output port err_cnt [7:0]. It counts proto_err pulses, saturates at 8'hFF, and resets to 0 on reset_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then nibbles 3,3,3,2 (RS=0), then byte 0x28 -> state S_HI, byte_valid once with byte_data=0x28, byte_rs=0, rows all 0x20.
- After init: 0x80, then data "AB" -> row_A[0:15]="AB", addr=0x02. Then 0xC0 + 16 data bytes "0123456789ABCDEF" -> row_B = that string, frame_update exactly once, on the 16th byte.
- Set addr 0x27, write 'X' -> rows unchanged, addr=0x40. Entry mode 0x04, set 0x40, write 'Y' -> row_B[0:7]="Y", addr=0x27.
- E pulse of 1 cycle with E_MIN_HIGH=2 -> ignored. High nibble RS=0, low nibble RS=1 -> proto_err one cycle, no byte_valid. The next correct pair decodes normally.
- Write 'Z' at 0x05, then command 0x01 -> rows all 0x20, addr=0. RW=1 strobe -> proto_err. With LCD_DEC_ERR_CNT_EN, err_cnt increments each time and saturates at 255 after 300 errors.
- Assert reset_n low between the high and low nibble -> outputs return to reset values. The following 4'h2-init sequence is required before bytes decode again.

Source files
------------

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: receive side of the 4-bit HD44780-style LCD bus.
// Synchronizes the bus, detects filtered LCD_E falling edges, pairs nibbles
// into bytes, decodes the command subset and keeps a 2x16 shadow display.
// Optional build macro LCD_DEC_ERR_CNT_EN adds a saturating 8-bit count of
// protocol errors on port err_cnt.
module lcd_bus_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int E_MIN_HIGH  = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         LCD_E,
   input  logic         LCD_RS,
   input  logic         LCD_RW,
   input  logic [3:0]   LCD_D,
   output logic [0:127] row_A,
   output logic [0:127] row_B,
   output logic         byte_valid,
   output logic [7:0]   byte_data,
   output logic         byte_rs,
   output logic         frame_update,
   output logic         proto_err
`ifdef LCD_DEC_ERR_CNT_EN
   ,
   output logic [7:0]   err_cnt
`endif
);

   // High-time counter only needs to reach E_MIN_HIGH, then it saturates.
   localparam int HW = (E_MIN_HIGH < 2) ? 1 : $clog2(E_MIN_HIGH + 1);
   localparam logic [HW-1:0] HMAX = HW'(E_MIN_HIGH);
   localparam logic [0:127]  BLANK_ROW = {16{8'h20}};

   typedef enum logic [1:0] {
      S_MODE8 = 2'd0,
      S_HI    = 2'd1,
      S_LO    = 2'd2
   } state_t;

   // Bus bundle layout: {E, RS, RW, D[3:0]}
   logic [6:0] bus_raw;
   logic [6:0] sync_q [SYNC_STAGES];
   logic [6:0] bus_s;
   logic       e_s;

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          last_rs_q;
   logic          last_rw_q;
   logic [3:0]    last_d_q;
   logic          strobe;

   state_t     state_q, state_d;
   logic [3:0] hi_nib_q, hi_nib_d;
   logic       hi_rs_q, hi_rs_d;
   logic       byte_fire;
   logic       byte_err;
   logic [7:0] new_byte;

   logic [0:127] row_a_q, row_a_d;
   logic [0:127] row_b_q, row_b_d;
   logic [6:0]   addr_q, addr_d;
   logic         inc_q, inc_d;
   logic         frame_d;

   logic         byte_valid_q;
   logic [7:0]   byte_data_q;
   logic         byte_rs_q;
   logic         frame_update_q;
   logic         proto_err_q;

   assign bus_raw = {LCD_E, LCD_RS, LCD_RW, LCD_D};
   assign bus_s   = sync_q[SYNC_STAGES-1];
   assign e_s     = bus_s[6];

   // Synchronizer chain: every bus wire goes through SYNC_STAGES flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus_raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Count consecutive E-high cycles, saturating at the acceptance threshold.
   always_comb begin
      hcnt_d = '0;
      if (e_s) hcnt_d = (hcnt_q == HMAX) ? hcnt_q : hcnt_q + 1'b1;
   end

   // Track E-high time and remember the bus contents of the last E-high cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcnt_q    <= '0;
         last_rs_q <= 1'b0;
         last_rw_q <= 1'b0;
         last_d_q  <= 4'h0;
      end else begin
         hcnt_q <= hcnt_d;
         if (e_s) begin
            last_rs_q <= bus_s[5];
            last_rw_q <= bus_s[4];
            last_d_q  <= bus_s[3:0];
         end
      end
   end

   // A non-zero counter implies E was high last cycle, so E low now is a fall.
   assign strobe   = !e_s && (hcnt_q == HMAX);
   assign new_byte = {hi_nib_q, last_d_q};

   // Nibble-pairing FSM: next state, nibble latch and byte/error events.
   always_comb begin
      state_d   = state_q;
      hi_nib_d  = hi_nib_q;
      hi_rs_d   = hi_rs_q;
      byte_fire = 1'b0;
      byte_err  = 1'b0;
      if (strobe) begin
         if (last_rw_q) begin
            // Reads are not part of the driver protocol; pairing is untouched.
            byte_err = 1'b1;
         end else begin
            case (state_q)
               S_MODE8: begin
                  if (last_rs_q)              byte_err = 1'b1;
                  else if (last_d_q == 4'h2)  state_d  = S_HI;
               end
               S_HI: begin
                  hi_nib_d = last_d_q;
                  hi_rs_d  = last_rs_q;
                  state_d  = S_LO;
               end
               S_LO: begin
                  if (last_rs_q == hi_rs_q) byte_fire = 1'b1;
                  else                      byte_err  = 1'b1;
                  state_d = S_HI;
               end
               default: state_d = S_MODE8;
            endcase
         end
      end
   end

   // FSM state and high-nibble holding registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_MODE8;
         hi_nib_q <= 4'h0;
         hi_rs_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_nib_q <= hi_nib_d;
         hi_rs_q  <= hi_rs_d;
      end
   end

   // DDRAM address auto-step, following the two-line 0x00-0x27/0x40-0x67 map.
   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
      logic [6:0] r;
      if (up) begin
         case (a)
            7'h27:   r = 7'h40;
            7'h67:   r = 7'h00;
            default: r = a + 7'd1;
         endcase
      end else begin
         case (a)
            7'h00:   r = 7'h67;
            7'h40:   r = 7'h27;
            default: r = a - 7'd1;
         endcase
      end
      return r;
   endfunction

   // Byte interpretation: data writes into the shadow rows, command decode.
   always_comb begin
      row_a_d = row_a_q;
      row_b_d = row_b_q;
      addr_d  = addr_q;
      inc_d   = inc_q;
      frame_d = 1'b0;
      if (byte_fire) begin
         if (hi_rs_q) begin
            if (addr_q[6:4] == 3'b000)
               row_a_d[{addr_q[3:0], 3'b000} +: 8] = new_byte;
            else if (addr_q[6:4] == 3'b100)
               row_b_d[{addr_q[3:0], 3'b000} +: 8] = new_byte;
            frame_d = (addr_q == 7'h4F);
            addr_d  = addr_step(addr_q, inc_q);
         end else begin
            casez (new_byte)
               8'b1???????: addr_d = new_byte[6:0];
               8'b01??????: begin end   // CGRAM address
               8'b001?????: begin end   // function set
               8'b0001????: begin end   // cursor/display shift
               8'b00001???: begin end   // display on/off
               8'b000001??: inc_d = new_byte[1];
               8'b0000001?: addr_d = 7'h00;
               8'b00000001: begin
                  row_a_d = BLANK_ROW;
                  row_b_d = BLANK_ROW;
                  addr_d  = 7'h00;
                  inc_d   = 1'b1;
               end
               default: begin end
            endcase
         end
      end
   end

   // Shadow display, address/entry mode and one-cycle event outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_a_q        <= BLANK_ROW;
         row_b_q        <= BLANK_ROW;
         addr_q         <= 7'h00;
         inc_q          <= 1'b1;
         byte_valid_q   <= 1'b0;
         byte_data_q    <= 8'h00;
         byte_rs_q      <= 1'b0;
         frame_update_q <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         row_a_q        <= row_a_d;
         row_b_q        <= row_b_d;
         addr_q         <= addr_d;
         inc_q          <= inc_d;
         byte_valid_q   <= byte_fire;
         frame_update_q <= frame_d;
         proto_err_q    <= byte_err;
         if (byte_fire) begin
            byte_data_q <= new_byte;
            byte_rs_q   <= hi_rs_q;
         end
      end
   end

`ifdef LCD_DEC_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count of protocol errors since reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            err_cnt_q <= 8'h00;
      else if (byte_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_cnt = err_cnt_q;
`endif

   assign row_A        = row_a_q;
   assign row_B        = row_b_q;
   assign byte_valid   = byte_valid_q;
   assign byte_data    = byte_data_q;
   assign byte_rs      = byte_rs_q;
   assign frame_update = frame_update_q;
   assign proto_err    = proto_err_q;

endmodule
